convolution_processor_ctrl: RTL

//  Sequencer for the convolution core. Drives read addresses into two single-port ROMs (X, Y),

---
 rtl/convolution_processor_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/convolution_processor_ctrl.sv
// Convolution sequencer: walks X/Y ROM addresses, accumulates products and writes Z[i].
// Optional cycle counter output enabled by defining CONV_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start_i; sizes latched on accept
// FETCH | issue one X/Y address pair per cycle for the current output i
// DRAIN | last product of output i arrives and accumulates
// WRITE | one-cycle Z write of the finished sum
// DONE  | one-cycle done_o pulse, then back to IDLE
module convolution_processor_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH_X = 4,
   parameter int ADDR_WIDTH_Y = 4,
   parameter int ADDR_WIDTH_Z = 5,
   parameter int ACC_WIDTH    = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH_X:0]   size_x_i,
   input  logic [ADDR_WIDTH_Y:0]   size_y_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [ADDR_WIDTH_X-1:0] addr_x_o,
   input  logic [DATA_WIDTH-1:0]   data_x_i,
   output logic [ADDR_WIDTH_Y-1:0] addr_y_o,
   input  logic [DATA_WIDTH-1:0]   data_y_i,
   output logic                    we_z_o,
   output logic [ADDR_WIDTH_Z-1:0] addr_z_o,
   output logic [ACC_WIDTH-1:0]    data_z_o
`ifdef CONV_CTRL_PERF_EN
   ,
   output logic [31:0]             cycle_cnt_o
`endif
);

   // Index arithmetic is carried two bits wider than the Z address so that
   // i+1, Nx and Ny never wrap for any legal parameter combination.
   localparam int CW = ADDR_WIDTH_Z + 2;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state_q;

   logic [CW-1:0]        nx_q, ny_q, last_i_q, i_q, j_q, jhi_q;
   logic [CW-1:0]        nx_src, ny_src, i_nxt, jlo_nxt, jhi_nxt, y_nxt, j_inc;
   logic                 acc_vld_q;
   logic [ACC_WIDTH-1:0] acc_q, acc_nxt;
   logic [PW-1:0]        prod;
   logic                 accept;

   assign accept = (state_q == S_IDLE) && start_i;

   // Window for the next output index; from IDLE it is computed from the live size inputs.
   always_comb begin
      nx_src  = (state_q == S_IDLE) ? CW'(size_x_i) : nx_q;
      ny_src  = (state_q == S_IDLE) ? CW'(size_y_i) : ny_q;
      i_nxt   = (state_q == S_IDLE) ? '0 : i_q + CW'(1);
      jlo_nxt = ((i_nxt + CW'(1)) > ny_src) ? (i_nxt + CW'(1) - ny_src) : '0;
      jhi_nxt = (i_nxt < nx_src) ? i_nxt : (nx_src - CW'(1));
      y_nxt   = i_nxt - jlo_nxt;
      j_inc   = j_q + CW'(1);
      prod    = data_x_i * data_y_i;
      acc_nxt = acc_q + {{(ACC_WIDTH-PW){1'b0}}, prod};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         nx_q      <= '0;
         ny_q      <= '0;
         last_i_q  <= '0;
         i_q       <= '0;
         j_q       <= '0;
         jhi_q     <= '0;
         acc_q     <= '0;
         acc_vld_q <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         addr_x_o  <= '0;
         addr_y_o  <= '0;
         we_z_o    <= 1'b0;
         addr_z_o  <= '0;
         data_z_o  <= '0;
      end else begin
         // ROM data lags its address by one cycle, so accumulation follows FETCH by one cycle.
         acc_vld_q <= (state_q == S_FETCH);
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  nx_q     <= nx_src;
                  ny_q     <= ny_src;
                  last_i_q <= nx_src + ny_src - CW'(2);
                  i_q      <= '0;
                  busy_o   <= 1'b1;
                  if (nx_src == '0 || ny_src == '0) begin
                     state_q <= S_DONE;
                     done_o  <= 1'b1;
                  end else begin
                     state_q  <= S_FETCH;
                     j_q      <= jlo_nxt;
                     jhi_q    <= jhi_nxt;
                     addr_x_o <= jlo_nxt[ADDR_WIDTH_X-1:0];
                     addr_y_o <= y_nxt[ADDR_WIDTH_Y-1:0];
                     acc_q    <= '0;
                  end
               end
            end
            S_FETCH: begin
               if (acc_vld_q) acc_q <= acc_nxt;
               if (j_q == jhi_q) begin
                  state_q <= S_DRAIN;
               end else begin
                  j_q      <= j_inc;
                  addr_x_o <= j_inc[ADDR_WIDTH_X-1:0];
                  addr_y_o <= addr_y_o - ADDR_WIDTH_Y'(1);
               end
            end
            S_DRAIN: begin
               acc_q    <= acc_nxt;
               data_z_o <= acc_nxt;
               addr_z_o <= i_q[ADDR_WIDTH_Z-1:0];
               we_z_o   <= 1'b1;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               we_z_o <= 1'b0;
               if (i_q < last_i_q) begin
                  state_q  <= S_FETCH;
                  i_q      <= i_nxt;
                  j_q      <= jlo_nxt;
                  jhi_q    <= jhi_nxt;
                  addr_x_o <= jlo_nxt[ADDR_WIDTH_X-1:0];
                  addr_y_o <= y_nxt[ADDR_WIDTH_Y-1:0];
                  acc_q    <= '0;
               end else begin
                  state_q <= S_DONE;
                  done_o  <= 1'b1;
               end
            end
            S_DONE: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef CONV_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_o <= '0;
      end else if (accept) begin
         cycle_cnt_o <= '0;
      end else if (busy_o && cycle_cnt_o != 32'hFFFF_FFFF) begin
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
   end
`endif

endmodule
